// File: rtl/snake_step_scheduler_pkg.sv
// snake_step_scheduler_pkg: direction codes, grid defaults and FSM states shared by the step scheduler
package snake_step_scheduler_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;
  localparam int DEF_GRID_W = 40;
  localparam int DEF_GRID_H = 30;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SHIFT_RD, S_SHIFT_WR, S_HEAD, S_OVER} state_t;
  // Opposite directions differ only in bit 1 (up/down, right/left)
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction
endpackage

// File: rtl/snake_step_scheduler_vsync_tick_gen.sv
// snake_step_scheduler_vsync_tick_gen: counts vsync falling edges, one tick every TICK_FRAMES frames
module snake_step_scheduler_vsync_tick_gen #(
  parameter int TICK_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  input  logic pause,
  output logic tick
);
  localparam int FW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FW-1:0] LAST = FW'(TICK_FRAMES - 1);
  logic vs_q;
  logic adv;
  logic [FW-1:0] frame_cnt;
  assign adv  = vs_q && !vsync && !pause;
  assign tick = adv && frame_cnt == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vs_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_q <= vsync;
      if (adv) frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
    end
endmodule

// File: rtl/snake_step_scheduler.sv
// snake_step_scheduler: one snake step per tick, shifting body and writing head into the segment RAM.
// Define SNAKE_WRAP_EN to wrap the head around grid edges instead of ending the game.
module snake_step_scheduler
  import snake_step_scheduler_pkg::*;
#(
  parameter int COORD_W     = 6,
  parameter int ADDR_W      = 6,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int TICK_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic [1:0]           dir,
  input  logic                 pause,
  input  logic                 grow,
  input  logic [2*COORD_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [2*COORD_W-1:0] mem_wdata,
  output logic                 mem_we,
  output logic [ADDR_W:0]      snake_len,
  output logic [COORD_W-1:0]   head_x,
  output logic [COORD_W-1:0]   head_y,
  output logic                 busy,
  output logic                 step_done,
  output logic                 game_over
);
  localparam logic [ADDR_W:0] MAXL  = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] INITL = (ADDR_W+1)'(INIT_LEN);
  localparam logic [COORD_W-1:0] XC = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] YC = COORD_W'(GRID_H / 2);
  localparam logic signed [COORD_W:0] GW  = (COORD_W+1)'(GRID_W);
  localparam logic signed [COORD_W:0] GH  = (COORD_W+1)'(GRID_H);
  localparam logic signed [COORD_W:0] ONE = 1;
  state_t state;
  logic tick, tick_pend, grow_pend, pass, off;
  logic [1:0] dir_q, d;
  logic [ADDR_W:0] i, new_len;
  logic [2*COORD_W-1:0] nh, nh_q, wdata_q;
  logic signed [COORD_W:0] nx, ny;
  snake_step_scheduler_vsync_tick_gen #(.TICK_FRAMES(TICK_FRAMES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .pause (pause),
    .tick  (tick)
  );
  assign d  = is_reversal(dir, dir_q) ? dir_q : dir;
  assign nx = $signed({1'b0, head_x}) + (d == DIR_RIGHT ? ONE : d == DIR_LEFT ? -ONE : '0);
  assign ny = $signed({1'b0, head_y}) + (d == DIR_DOWN ? ONE : d == DIR_UP ? -ONE : '0);
  assign new_len = snake_len + (ADDR_W+1)'(grow_pend && snake_len < MAXL);
  // During SHIFT_WR the word read on the previous cycle passes straight through
  assign mem_wdata = pass ? mem_rdata : wdata_q;
`ifdef SNAKE_WRAP_EN
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(GRID_H - 1);
  logic [COORD_W-1:0] wx, wy;
  assign wx  = nx[COORD_W] ? XMAX : nx >= GW ? '0 : nx[COORD_W-1:0];
  assign wy  = ny[COORD_W] ? YMAX : ny >= GH ? '0 : ny[COORD_W-1:0];
  assign nh  = {wx, wy};
  assign off = 1'b0;
`else
  assign nh  = {nx[COORD_W-1:0], ny[COORD_W-1:0]};
  assign off = nx[COORD_W] || ny[COORD_W] || nx >= GW || ny >= GH;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= S_INIT;
      i         <= '0;
      dir_q     <= DIR_RIGHT;
      nh_q      <= '0;
      wdata_q   <= '0;
      pass      <= 1'b0;
      tick_pend <= 1'b0;
      grow_pend <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      snake_len <= INITL;
      head_x    <= XC;
      head_y    <= YC;
      busy      <= 1'b1;
      step_done <= 1'b0;
      game_over <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (tick && state != S_IDLE) tick_pend <= 1'b1;
      case (state)
        S_INIT:
          if (i == INITL) begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= ADDR_W'(i);
            wdata_q  <= {XC - COORD_W'(i), YC};
            i        <= i + 1'b1;
          end
        S_IDLE:
          if (tick || tick_pend) begin
            tick_pend <= 1'b0;
            dir_q     <= d;
            if (off) begin
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              nh_q      <= nh;
              snake_len <= new_len;
              grow_pend <= 1'b0;
              i         <= new_len - 1'b1;
              mem_addr  <= ADDR_W'(new_len - 2'd2);
              busy      <= 1'b1;
              state     <= S_SHIFT_RD;
            end
          end
        S_SHIFT_RD: begin
          mem_addr <= ADDR_W'(i);
          mem_we   <= 1'b1;
          pass     <= 1'b1;
          state    <= S_SHIFT_WR;
        end
        S_SHIFT_WR: begin
          pass <= 1'b0;
          i    <= i - 1'b1;
          if (i == 1) begin
            mem_addr <= '0;
            wdata_q  <= nh_q;
            state    <= S_HEAD;
          end else begin
            mem_addr <= ADDR_W'(i - 2'd2);
            mem_we   <= 1'b0;
            state    <= S_SHIFT_RD;
          end
        end
        S_HEAD: begin
          mem_we    <= 1'b0;
          head_x    <= nh_q[2*COORD_W-1:COORD_W];
          head_y    <= nh_q[COORD_W-1:0];
          step_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_OVER: ;
        default: state <= S_INIT;
      endcase
      // A new grow pulse wins over the clear done when a step consumes the old one
      if (grow && snake_len < MAXL) grow_pend <= 1'b1;
    end
endmodule
